alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter WIDTH, default 32, data width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction word and operands offered.
REQ-005 instr_ready  output  1  block accepts the offered instruction this cycle.
REQ-006 instr  input  32  MIPS instruction word; op = [31:26], rd = [15:11], shamt = [10:6], funct = [5:0].
REQ-007 rs_val, rt_val  input  WIDTH each  source operand values, sampled with instr.
REQ-008 alu_in1, alu_in2  output  WIDTH each  registered ALU operands.
REQ-009 alu_opcode  output  6  registered ALU function code.
REQ-010 alu_out  input  WIDTH; alu_zero  input  1  combinational ALU result and zero flag.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer takes the result.
REQ-013 res_data  output  WIDTH; res_zero  output  1; res_rd  output  5; res_illegal  output  1  captured result, zero flag, destination and illegal flag.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, EXEC and RESULT.
REQ-015 instr_ready SHALL be 1 in IDLE, 1 in RESULT when res_ready=1, and 0 otherwise.
REQ-016 A transfer SHALL occur when instr_valid=1 and instr_ready=1. On a transfer: latch rs_val into alu_in1 and rt_val into alu_in2, latch the decoded opcode and rd, then go to EXEC.
REQ-017 Decode: op=0 with funct 6'b100000 (add) or 6'b100010 (sub) SHALL be legal, with alu_opcode=funct; any other word SHALL be illegal, with alu_opcode=6'b000000 and the illegal flag set.
REQ-018 In EXEC, the block SHALL capture alu_out into res_data and alu_zero into res_zero, and go to RESULT.
REQ-019 In RESULT, res_valid SHALL be 1 and all res_* outputs SHALL hold stable until res_ready=1.
REQ-020 Next state from RESULT: res_ready=1 with a new transfer goes to EXEC; res_ready=1 with no transfer goes to IDLE; res_ready=0 stays in RESULT.
REQ-021 Latency from transfer to res_valid SHALL be 2 cycles; throughput SHALL be one instruction per 2 cycles when back-to-back.
REQ-022 alu_in1, alu_in2 and alu_opcode SHALL hold their last values while no transfer occurs.
REQ-023 An illegal instruction SHALL still complete the full sequence; res_data=0, res_zero=1 and res_illegal=1.
REQ-024 Add and sub results SHALL be modulo 2^WIDTH; overflow is not flagged.
REQ-025 instr_valid SHALL be ignored in EXEC; the producer keeps instr stable until the transfer.

Reset
REQ-026 While rst=1, at the clock edge: state is IDLE, res_valid=0, and res_data, res_zero, res_rd, res_illegal, alu_in1, alu_in2 and alu_opcode are all 0.
REQ-027 A reset in EXEC or RESULT SHALL discard the in-flight instruction with no result emitted.
REQ-028 instr_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 With macro ALU_ISSUE_SHAMT_CHECK_EN defined, an R-type add/sub with shamt≠0 SHALL be illegal.
REQ-030 Without ALU_ISSUE_SHAMT_CHECK_EN, shamt SHALL be ignored.

Structure
REQ-031 Shared package alu_pkg SHALL hold FUNCT_ADD=6'b100000, FUNCT_SUB=6'b100010, OP_RTYPE=6'b000000 and the FSM state encoding.
REQ-032 Decode SHALL be a combinational sub-module alu_funct_dec (inputs instr; outputs opcode, illegal); the FSM and registers stay in alu_issue.

Verification
REQ-033 Add: instr op=0, rd=3, funct=100000, rs=5, rt=7, res_ready=1 -> res_valid 2 cycles after transfer, res_data=12, res_zero=0, res_rd=3, res_illegal=0.
REQ-034 Sub to zero: funct=100010, rs=rt=0x1234 -> res_data=0, res_zero=1; then rs=0, rt=1 -> res_data=0xFFFFFFFF.
REQ-035 Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_* stable, instr_ready=0; release -> one handshake, then next instruction accepted the same cycle.
REQ-036 Illegal: op=6'b100011 (lw) -> alu_opcode=0, res_data=0, res_zero=1, res_illegal=1; with the macro defined, add with shamt=1 also gives res_illegal=1.
REQ-037 Back-to-back: 4 adds, instr_valid and res_ready held at 1 -> 4 results in cycles 2, 4, 6 and 8 after the first transfer, in order.
REQ-038 Reset in EXEC -> no res_valid afterwards, all outputs 0, instr_ready=1 in the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared decode constants and issue FSM encoding for alu_issue
package alu_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic logic is_addsub(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB);
    endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// rtl/alu_funct_dec.sv - combinational R-type add/sub decoder
// ALU_ISSUE_SHAMT_CHECK_EN: add/sub with a nonzero shamt field decodes as illegal.
module alu_funct_dec (
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        illegal
);
    import alu_pkg::*;

    logic legal;
    logic unused_bits;

`ifdef ALU_ISSUE_SHAMT_CHECK_EN
    assign unused_bits = ^instr[25:16];
`else
    assign unused_bits = ^{instr[25:16], instr[10:6]};
`endif

    always_comb begin
        legal = (instr[31:26] == OP_RTYPE) && is_addsub(instr[5:0]);
`ifdef ALU_ISSUE_SHAMT_CHECK_EN
        legal = legal && (instr[10:6] == 5'd0);
`endif
        opcode  = legal ? instr[5:0] : 6'b000000;
        illegal = !legal;
    end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-entry issue stage feeding an external ALU and holding its result
// ALU_ISSUE_SHAMT_CHECK_EN: forwarded to alu_funct_dec to reject add/sub with nonzero shamt.
module alu_issue #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [5:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [4:0]       res_rd,
    output logic             res_illegal
);
    import alu_pkg::*;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [4:0]       rd_q, rd_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic [4:0]       res_rd_q, res_rd_d;
    logic             res_illegal_q, res_illegal_d;

    logic [5:0] dec_opcode;
    logic       dec_illegal;
    logic       transfer;

    alu_funct_dec u_dec (
        .instr   (instr),
        .opcode  (dec_opcode),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d       = state_q;
        in1_d         = in1_q;
        in2_d         = in2_q;
        opcode_d      = opcode_q;
        rd_d          = rd_q;
        illegal_d     = illegal_q;
        res_data_d    = res_data_q;
        res_zero_d    = res_zero_q;
        res_rd_d      = res_rd_q;
        res_illegal_d = res_illegal_q;

        instr_ready = (state_q == IDLE) || ((state_q == RESULT) && res_ready);
        transfer    = instr_valid && instr_ready;

        case (state_q)
            IDLE: begin
                if (transfer) state_d = EXEC;
            end
            EXEC: begin
                // Illegal words still flow through; their result is forced to a zero value.
                res_data_d    = illegal_q ? '0 : alu_out;
                res_zero_d    = illegal_q | alu_zero;
                res_rd_d      = rd_q;
                res_illegal_d = illegal_q;
                state_d       = RESULT;
            end
            RESULT: begin
                if (res_ready) state_d = transfer ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (transfer) begin
            in1_d     = rs_val;
            in2_d     = rt_val;
            opcode_d  = dec_opcode;
            rd_d      = instr[15:11];
            illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            in1_q         <= '0;
            in2_q         <= '0;
            opcode_q      <= '0;
            rd_q          <= '0;
            illegal_q     <= 1'b0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_rd_q      <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            opcode_q      <= opcode_d;
            rd_q          <= rd_d;
            illegal_q     <= illegal_d;
            res_data_q    <= res_data_d;
            res_zero_q    <= res_zero_d;
            res_rd_q      <= res_rd_d;
            res_illegal_q <= res_illegal_d;
        end
    end

    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_opcode  = opcode_q;
    assign res_valid   = (state_q == RESULT);
    assign res_data    = res_data_q;
    assign res_zero    = res_zero_q;
    assign res_rd      = res_rd_q;
    assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with an external behavioural ALU
module tb_alu_issue;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [W-1:0]  rs_val, rt_val;
    logic [W-1:0]  alu_in1, alu_in2;
    logic [5:0]    alu_opcode;
    logic [W-1:0]  alu_out;
    logic          alu_zero;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          res_zero;
    logic [4:0]    res_rd;
    logic          res_illegal;

    alu_issue #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_opcode  (alu_opcode),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .res_rd      (res_rd),
        .res_illegal (res_illegal)
    );

    always #5 clk = ~clk;

    // External ALU; unknown codes give a nonzero value so illegal results must be forced.
    assign alu_out  = (alu_opcode == 6'h20) ? alu_in1 + alu_in2 :
                      (alu_opcode == 6'h22) ? alu_in1 - alu_in2 : (alu_in1 | 32'h1);
    assign alu_zero = (alu_out == '0);

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
        logic [4:0]   rd;
        logic         ill;
    } exp_t;

    function automatic exp_t model(input logic [31:0] w, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic legal;
        legal = (w[31:26] == 6'd0) && (w[5:0] == 6'h20 || w[5:0] == 6'h22);
`ifdef ALU_ISSUE_SHAMT_CHECK_EN
        legal = legal && (w[10:6] == 5'd0);
`endif
        if (!legal)              r.data = '0;
        else if (w[5:0] == 6'h20) r.data = W'((64'(a) + 64'(b)) % (64'd1 << W));
        else                     r.data = W'((64'(a) + (64'd1 << W) - 64'(b)) % (64'd1 << W));
        r.zero = (r.data == '0);
        r.rd   = w[15:11];
        r.ill  = !legal;
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        logic [9:0] regs;
        regs = 10'($urandom);
        return {op, regs, rd, sh, fn};
    endfunction

    // Scoreboard monitor: pops on each result handshake, pushes on each instruction transfer.
    exp_t sbq[$];
    exp_t e, prev;
    logic held = 1'b0;
    int   m_tests = 0, m_fails = 0;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            held <= 1'b0;
        end else begin
            if (res_valid) begin
                if (held) begin
                    m_tests++;
                    if ({res_data, res_zero, res_rd, res_illegal} != prev) begin
                        m_fails++;
                        $display("FAIL hold_stable got %h want %h", {res_data, res_zero, res_rd, res_illegal}, prev);
                    end
                end
                if (res_ready) begin
                    m_tests++;
                    if (sbq.size() == 0) begin
                        m_fails++;
                        $display("FAIL unexpected_result got data=%h with empty scoreboard", res_data);
                    end else begin
                        e = sbq.pop_front();
                        if ({res_data, res_zero, res_rd, res_illegal} != e) begin
                            m_fails++;
                            $display("FAIL result got data=%h zero=%b rd=%0d ill=%b want data=%h zero=%b rd=%0d ill=%b",
                                     res_data, res_zero, res_rd, res_illegal, e.data, e.zero, e.rd, e.ill);
                        end
                    end
                    held <= 1'b0;
                end else begin
                    held <= 1'b1;
                    prev = {res_data, res_zero, res_rd, res_illegal};
                end
            end else begin
                held <= 1'b0;
            end
            if (instr_valid && instr_ready) sbq.push_back(model(instr, rs_val, rt_val));
        end
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        instr = w; rs_val = a; rt_val = b; instr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (instr_ready) ok = 1'b1;
        end
        if (!ok) check("transfer_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    logic [9:0] pattern;
    int         sent;
    logic       xfer, seen;
    int         k;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; res_ready = 1'b1;
        instr = '0; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_outputs", {res_data, res_zero, res_rd, res_illegal, alu_in1[25:0]}, 64'd0);
        check("reset_alu", {alu_in1, alu_in2[25:0], alu_opcode}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(instr_ready), 64'd1);
        @(posedge clk); #1;

        // Directed add with latency probe
        send(mk(6'd0, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
        @(negedge clk);
        check("lat_cycle1_valid", 64'(res_valid), 64'd0);
        check("add_alu_opcode", 64'(alu_opcode), 64'h20);
        check("add_operands", {alu_in1, alu_in2}, {32'd5, 32'd7});
        @(negedge clk);
        check("lat_cycle2_valid", 64'(res_valid), 64'd1);
        @(posedge clk); #1;

        send(mk(6'd0, 5'd4, 5'd0, 6'h22), 32'h1234, 32'h1234);
        repeat (2) @(posedge clk); #1;
        send(mk(6'd0, 5'd5, 5'd0, 6'h22), 32'd0, 32'd1);
        repeat (2) @(posedge clk); #1;

        send(mk(6'b100011, 5'd6, 5'd0, 6'h20), 32'd9, 32'd9);
        @(negedge clk);
        check("illegal_alu_opcode", 64'(alu_opcode), 64'd0);
        @(posedge clk); #1;
        send(mk(6'd0, 5'd7, 5'd1, 6'h20), 32'd2, 32'd3);
        repeat (2) @(posedge clk); #1;

        // Backpressure: result held 5 cycles, next instruction waits then transfers on release
        res_ready = 1'b0;
        send(mk(6'd0, 5'd8, 5'd0, 6'h20), 32'd9, 32'd10);
        instr = mk(6'd0, 5'd9, 5'd0, 6'h22); rs_val = 32'd100; rt_val = 32'd1; instr_valid = 1'b1;
        @(negedge clk);
        check("exec_ignores_valid", 64'(instr_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {res_valid, instr_ready}, {1'b1, 1'b0});
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_accept", {res_valid, instr_ready}, {1'b1, 1'b1});
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("bp_after_release", 64'(res_valid), 64'd0);
        repeat (2) @(posedge clk); #1;

        // Back-to-back: four adds with valid and ready held high
        instr = mk(6'd0, 5'd10, 5'd0, 6'h20); rs_val = 32'd1; rt_val = 32'd1; instr_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_accept", 64'(instr_ready), 64'd1);
        sent = 1; pattern = '0;
        @(posedge clk); #1;
        instr = mk(6'd0, 5'd11, 5'd0, 6'h20); rs_val = 32'd2; rt_val = 32'd2;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            pattern[c] = res_valid;
            xfer = instr_valid && instr_ready;
            @(posedge clk); #1;
            if (xfer) begin
                sent++;
                if (sent < 4) begin
                    instr = mk(6'd0, 5'(10 + sent), 5'd0, 6'h20);
                    rs_val = 32'(sent + 1); rt_val = 32'(sent + 1);
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        check("b2b_valid_cycles", 64'(pattern), 64'b0101010100);
        check("b2b_sent", 64'(sent), 64'd4);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            xfer = instr_valid && instr_ready;
            @(posedge clk); #1;
            if (xfer || !instr_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    k = $urandom_range(0, 3);
                    case (k)
                        0: instr = mk(6'd0, 5'($urandom), 5'd0, 6'h20);
                        1: instr = mk(6'd0, 5'($urandom), 5'd0, 6'h22);
                        2: instr = $urandom;
                        default: instr = mk(6'd0, 5'($urandom), 5'($urandom), ($urandom_range(0, 1) != 0) ? 6'h20 : 6'h22);
                    endcase
                    rs_val = $urandom;
                    rt_val = ($urandom_range(0, 3) == 0) ? rs_val : W'($urandom);
                    instr_valid = 1'b1;
                end else begin
                    instr_valid = 1'b0;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        // Holding valid while the producer waits keeps instr stable
        @(negedge clk);
        xfer = instr_valid && instr_ready;
        @(posedge clk); #1;
        instr_valid = xfer ? 1'b0 : instr_valid;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            xfer = instr_valid && instr_ready;
            @(posedge clk); #1;
            if (xfer) instr_valid = 1'b0;
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);

        // Reset while in EXEC drops the instruction
        send(mk(6'd0, 5'd12, 5'd0, 6'h20), 32'd1, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_exec_ready", 64'(instr_ready), 64'd1);
        check("rst_exec_res", {res_valid, res_data, res_zero, res_rd, res_illegal}, 64'd0);
        check("rst_exec_alu", {alu_in1, alu_opcode}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("rst_exec_no_result", 64'(seen), 64'd0);
        check("rst_exec_sb_empty", 64'(sbq.size()), 64'd0);

        tests += m_tests;
        fails += m_fails;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
